// File: rtl/arm_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arm_irq_ctrl
// Purpose  : N_IRQ-channel interrupt controller in front of the ARM core's
//            single Interrupt input. Maskable channels, per-channel edge or
//            level mode, fixed lowest-index-first priority and a vector ID.
//            Uses a request / acknowledge / end-of-interrupt handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            irq_in     - raw interrupt sources (asynchronous to clk)
//            cfg_we     - register write strobe
//            cfg_addr   - 0 MASK, 1 EDGE, 2 PEND (W1C), 3 STATUS (RO)
//            cfg_wdata  - register write data
//            cfg_rdata  - combinational read data, zero-extended to 32 bits
//            int_ack    - acknowledge pulse from the core (IntReset)
//            int_eoi    - end-of-interrupt pulse
//            Interrupt  - registered interrupt request to the core
//            int_id     - registered index of requested/serviced channel
// Revision : 1.0 - initial release
// ============================================================================
module arm_irq_ctrl #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [N_IRQ-1:0] cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             Interrupt,
    output logic [ID_W-1:0]  int_id
);

    localparam logic [1:0] C_ADDR_MASK   = 2'd0;
    localparam logic [1:0] C_ADDR_EDGE   = 2'd1;
    localparam logic [1:0] C_ADDR_PEND   = 2'd2;
    localparam logic [1:0] C_ADDR_STATUS = 2'd3;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_REQ     = 2'd1;
    localparam logic [1:0] C_ST_SERVICE = 2'd2;

    // Register file and synchronizer
    logic [N_IRQ-1:0] sync1_q, sync1_d;
    logic [N_IRQ-1:0] sync2_q, sync2_d;   // synchronized source "s"
    logic [N_IRQ-1:0] sdly_q,  sdly_d;    // s delayed one cycle
    logic [N_IRQ-1:0] mask_q,  mask_d;
    logic [N_IRQ-1:0] edge_q,  edge_d;
    logic [N_IRQ-1:0] pend_q,  pend_d;

    // FSM and registered outputs
    logic [1:0]       state_q, state_d;
    logic             irq_q,   irq_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_id_sel;   // one-hot of the latched channel
    logic [N_IRQ-1:0] w_ack_clr;
    logic [N_IRQ-1:0] w_elig;
    logic             w_any_elig;
    logic             w_cur_elig;
    logic [ID_W-1:0]  w_win_id;

    // ------------------------------------------------------------------
    // Register next-state logic
    // ------------------------------------------------------------------
    always_comb begin : comb_regs
        sync1_d = irq_in;
        sync2_d = sync1_q;
        sdly_d  = sync2_q;
        mask_d  = mask_q;
        edge_d  = edge_q;
        if (cfg_we && (cfg_addr == C_ADDR_MASK)) begin
            mask_d = cfg_wdata;
        end
        if (cfg_we && (cfg_addr == C_ADDR_EDGE)) begin
            edge_d = cfg_wdata;
        end

        w_rise = sync2_q & ~sdly_q;
        w_w1c  = (cfg_we && (cfg_addr == C_ADDR_PEND)) ? cfg_wdata : '0;

        for (int i = 0; i < N_IRQ; i++) begin
            w_id_sel[i]  = (int_id_q == ID_W'(i));
            w_ack_clr[i] = w_id_sel[i] && int_ack && (state_q == C_ST_REQ);
        end

        // Edge channels: a new rising edge beats any clear in the same cycle.
        // Level channels simply track the synchronized source.
        for (int i = 0; i < N_IRQ; i++) begin
            if (edge_q[i]) begin
                pend_d[i] = (pend_q[i] & ~(w_w1c[i] | w_ack_clr[i])) | w_rise[i];
            end else begin
                pend_d[i] = sync2_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and fixed priority (lowest index wins)
    // ------------------------------------------------------------------
    always_comb begin : comb_prio
        w_elig     = pend_q & mask_q;
        w_any_elig = |w_elig;
        w_cur_elig = |(w_elig & w_id_sel);
        w_win_id   = '0;
        // Scan downwards so the lowest eligible index is the last to assign.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin : ff_state
        if (!reset) begin
            state_q  <= C_ST_IDLE;
            irq_q    <= 1'b0;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            int_id_q <= int_id_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin : comb_next
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_any_elig) begin
                    state_d = C_ST_REQ;
                end
            end
            C_ST_REQ: begin
                // Acknowledge takes precedence over a request being withdrawn.
                if (int_ack) begin
                    state_d = C_ST_SERVICE;
                end else if (!w_cur_elig) begin
                    state_d = C_ST_IDLE;
                end
            end
            C_ST_SERVICE: begin
                if (int_eoi) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (feeds the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin : comb_out
        irq_d    = (state_d == C_ST_REQ);
        int_id_d = int_id_q;
        // The ID is only captured on entry to REQ, so it holds through
        // REQ and SERVICE and later arrivals cannot preempt it.
        if ((state_q == C_ST_IDLE) && w_any_elig) begin
            int_id_d = w_win_id;
        end
    end

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin : ff_regs
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sdly_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '1;
            pend_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sdly_q  <= sdly_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin : comb_rd
        cfg_rdata = '0;
        case (cfg_addr)
            C_ADDR_MASK: cfg_rdata = 32'(mask_q);
            C_ADDR_EDGE: cfg_rdata = 32'(edge_q);
            C_ADDR_PEND: cfg_rdata = 32'(pend_q);
            C_ADDR_STATUS: begin
                cfg_rdata[9:8]      = state_q;
                cfg_rdata[ID_W-1:0] = int_id_q;
            end
            default: cfg_rdata = '0;
        endcase
    end

    assign Interrupt = irq_q;
    assign int_id    = int_id_q;

endmodule
`default_nettype wire
